// File: rtl/exec_issue_ctrl.sv
// Execute-stage issue controller: ALU operand/field selection, a 2-entry output skid buffer,
// flush, a saturating stall counter, and optional result forwarding (define EXEC_FWD_EN).
module exec_issue_ctrl #(
    parameter int N    = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      in_opcode,
    input  logic [2:0]      in_funct3,
    input  logic [6:0]      in_funct7,
    input  logic [RA_W-1:0] in_rs1,
    input  logic [RA_W-1:0] in_rs2,
    input  logic [RA_W-1:0] in_rd,
    input  logic [N-1:0]    in_reg_a,
    input  logic [N-1:0]    in_reg_b,
    input  logic [N-1:0]    in_imm,
    output logic [6:0]      alu_opcode,
    output logic [2:0]      alu_funct3,
    output logic [6:0]      alu_funct7,
    output logic [N-1:0]    alu_a,
    output logic [N-1:0]    alu_b,
    input  logic [N-1:0]    alu_result,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    out_result,
    output logic [RA_W-1:0] out_rd,
    output logic [6:0]      out_opcode,
    output logic [31:0]     stall_cnt
);

    localparam logic [6:0] OPCODE_REG_REG = 7'b0110011;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_t;

    typedef struct packed {
        logic [N-1:0]    result;
        logic [RA_W-1:0] rd;
        logic [6:0]      opcode;
    } entry_t;

    buf_state_t state, state_nxt;
    entry_t     head, skid, new_entry;
    logic       accept, pop;
    logic       load_head_new, load_head_skid, load_skid;

    assign alu_opcode = in_opcode;
    assign alu_funct3 = in_funct3;
    assign alu_funct7 = in_funct7;

    // Handshake flags come only from registered state, so out_ready never reaches in_ready.
    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign new_entry = '{result: alu_result, rd: in_rd, opcode: in_opcode};

    assign out_result = head.result;
    assign out_rd     = head.rd;
    assign out_opcode = head.opcode;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt      = state;
        load_head_new  = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt     = ONE;
                    load_head_new = 1'b1;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    load_head_new = 1'b1;
                end else if (accept) begin
                    state_nxt = TWO;
                    load_skid = 1'b1;
                end else if (pop) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    state_nxt      = ONE;
                    load_head_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
        end else if (!flush) begin
            if (load_head_new) begin
                head <= new_entry;
            end else if (load_head_skid) begin
                head <= skid;
            end
        end
    end

    // NOTE: the skid entry has no reset; it is only ever read after being written in state ONE.
    always_ff @(posedge clk) begin
        if (!flush && load_skid) begin
            skid <= new_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

`ifdef EXEC_FWD_EN
    localparam logic [6:0] OPCODE_REG_IMM = 7'b0010011;

    logic            fwd_valid;
    logic [RA_W-1:0] fwd_rd;
    logic [N-1:0]    fwd_data;
    logic            writes_reg;

    assign writes_reg = ((in_opcode == OPCODE_REG_REG) || (in_opcode == OPCODE_REG_IMM))
                        && (in_rd != '0);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            fwd_valid <= 1'b0;
        end else if (accept && writes_reg) begin
            fwd_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && accept && writes_reg) begin
            fwd_rd   <= in_rd;
            fwd_data <= alu_result;
        end
    end

    always_comb begin
        alu_a = in_reg_a;
        alu_b = (in_opcode == OPCODE_REG_REG) ? in_reg_b : in_imm;
        if (fwd_valid && (in_rs1 == fwd_rd)) begin
            alu_a = fwd_data;
        end
        if (fwd_valid && (in_rs2 == fwd_rd) && (in_opcode == OPCODE_REG_REG)) begin
            alu_b = fwd_data;
        end
    end
`else
    logic unused_fwd;

    assign alu_a      = in_reg_a;
    assign alu_b      = (in_opcode == OPCODE_REG_REG) ? in_reg_b : in_imm;
    assign unused_fwd = ^{in_rs1, in_rs2};
`endif

endmodule

// File: tb/tb_exec_issue_ctrl.sv
// Scoreboard bench for exec_issue_ctrl: directed scenarios plus random traffic against a
// queue-based reference model; honours EXEC_FWD_EN when the RTL is built with it.
module tb_exec_issue_ctrl;

    localparam logic [6:0] OP_RR   = 7'b0110011;
    localparam logic [6:0] OP_RI   = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
`ifdef EXEC_FWD_EN
    localparam logic [31:0] FWD_EXP = 32'd9;
`else
    localparam logic [31:0] FWD_EXP = 32'd1;
`endif

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic [6:0]  opcode;
    } exp_t;

    typedef struct {
        logic        valid;
        logic [6:0]  opcode;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] a, b, imm;
    } op_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [6:0]  in_opcode, in_funct7, alu_opcode, alu_funct7, out_opcode;
    logic [2:0]  in_funct3, alu_funct3;
    logic [4:0]  in_rs1, in_rs2, in_rd, out_rd;
    logic [31:0] in_reg_a, in_reg_b, in_imm, alu_a, alu_b, alu_result, out_result, stall_cnt;

    int checks = 0;
    int errors = 0;

    exp_t        sb[$];
    logic        tag_v = 1'b0;
    logic [4:0]  tag_rd = '0;
    logic [31:0] tag_data = '0;
    logic [31:0] exp_stall = '0;
    logic        pend_rst = 1'b1, pend_flush = 1'b0, pend_accept = 1'b0;
    exp_t        pend_item = '0;

    always #5 clk = ~clk;

    exec_issue_ctrl #(.N(32), .RA_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_reg_a(in_reg_a), .in_reg_b(in_reg_b), .in_imm(in_imm),
        .alu_opcode(alu_opcode), .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
        .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd), .out_opcode(out_opcode),
        .stall_cnt(stall_cnt)
    );

    // Behavioural RV32I ALU standing in for the shared combinational ALU.
    function automatic logic [31:0] alu_fn(input logic [6:0] op, input logic [2:0] f3,
                                           input logic [6:0] f7, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (f3)
            3'd0:    alu_fn = (op == OP_RR && f7 == F7_ALT) ? a - b : a + b;
            3'd1:    alu_fn = a << sh;
            3'd2:    alu_fn = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3:    alu_fn = (a < b) ? 32'd1 : 32'd0;
            3'd4:    alu_fn = a ^ b;
            3'd5:    alu_fn = (f7 == F7_ALT) ? 32'($signed(a) >>> sh) : a >> sh;
            3'd6:    alu_fn = a | b;
            default: alu_fn = a & b;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_opcode, alu_funct3, alu_funct7, alu_a, alu_b);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at posedge+1: present one cycle of inputs, check operands, record the model's
    // view of what the coming edge does, then advance to the next posedge+1.
    task automatic drive(input op_t o, input logic ordy, input logic fl, input logic r,
                         output logic acc);
        logic [31:0] ea, eb;
        in_valid  = o.valid;   in_opcode = o.opcode;  in_funct3 = o.f3;  in_funct7 = o.f7;
        in_rs1    = o.rs1;     in_rs2    = o.rs2;     in_rd     = o.rd;
        in_reg_a  = o.a;       in_reg_b  = o.b;       in_imm    = o.imm;
        out_ready = ordy;      flush     = fl;        rst       = r;
        ea = o.a;
        eb = (o.opcode == OP_RR) ? o.b : o.imm;
`ifdef EXEC_FWD_EN
        if (tag_v && o.rs1 == tag_rd) ea = tag_data;
        if (tag_v && o.rs2 == tag_rd && o.opcode == OP_RR) eb = tag_data;
`endif
        #1;
        check("alu_a", alu_a, ea);
        check("alu_b", alu_b, eb);
        check("alu_fields", {15'd0, alu_opcode, alu_funct3, alu_funct7}, {15'd0, o.opcode, o.f3, o.f7});
        acc         = o.valid && (sb.size() < 2) && !fl && !r;
        pend_rst    = r;
        pend_flush  = fl;
        pend_accept = acc;
        pend_item   = '{result: alu_fn(o.opcode, o.f3, o.f7, ea, eb), rd: o.rd, opcode: o.opcode};
        @(posedge clk);
        #1;
    endtask

    // Model commit at each edge: reset/flush empty the queue, otherwise accepts append.
    always @(posedge clk) begin
        if (pend_rst || pend_flush) begin
            sb.delete();
            tag_v = 1'b0;
        end else if (pend_accept) begin
            sb.push_back(pend_item);
            if ((pend_item.opcode == OP_RR || pend_item.opcode == OP_RI) && pend_item.rd != 0) begin
                tag_v    = 1'b1;
                tag_rd   = pend_item.rd;
                tag_data = pend_item.result;
            end
        end
    end

    // Monitor: mid-cycle comparison of handshake, counter and the popped head entry.
    always @(negedge clk) begin
        exp_t e;
        check("out_valid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
        check("in_ready", {31'd0, in_ready}, {31'd0, sb.size() < 2});
        check("stall_cnt", stall_cnt, exp_stall);
        if (rst) exp_stall = '0;
        else if (sb.size() != 0 && !out_ready && exp_stall != 32'hFFFF_FFFF) exp_stall++;
        if (!rst && !flush && out_ready && sb.size() != 0) begin
            e = sb.pop_front();
            check("out_result", out_result, e.result);
            check("out_rd", {27'd0, out_rd}, {27'd0, e.rd});
            check("out_opcode", {25'd0, out_opcode}, {25'd0, e.opcode});
        end
    end

    function automatic op_t mk(input logic v, input logic [6:0] op, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] imm);
        mk = '{valid: v, opcode: op, f3: f3, f7: f7, rs1: rs1, rs2: rs2, rd: rd, a: a, b: b, imm: imm};
    endfunction

    initial begin
        op_t  idle, o;
        logic acc;
        int   n;
        idle = mk(1'b0, OP_LOAD, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        in_valid = 0; in_opcode = 0; in_funct3 = 0; in_funct7 = 0; in_rs1 = 0; in_rs2 = 0;
        in_rd = 0; in_reg_a = 0; in_reg_b = 0; in_imm = 0; out_ready = 0; flush = 0; rst = 1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_result", out_result, 32'd0);
        check("reset_stall_cnt", stall_cnt, 32'd0);

        // Single ADD, then forwarding of its result into an ADDI with a stale operand.
        drive(mk(1, OP_RR, 3'd0, 7'd0, 5'd3, 5'd4, 5'd1, 32'd5, 32'd3, 32'd0), 1, 0, 0, acc);
        check("add_valid", {31'd0, out_valid}, 32'd1);
        check("add_result", out_result, 32'd8);
        drive(mk(1, OP_RI, 3'd0, 7'd0, 5'd1, 5'd0, 5'd2, 32'd0, 32'd0, 32'd1), 1, 0, 0, acc);
        check("fwd_result", out_result, FWD_EXP);
        drive(idle, 1, 0, 0, acc);

        // Backpressure: two accepts fill the buffer; the third waits for a pop.
        drive(mk(1, OP_RI, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd1), 0, 0, 0, acc);
        drive(mk(1, OP_RI, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd2), 0, 0, 0, acc);
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        o = mk(1, OP_RI, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd3);
        repeat (2) drive(o, 0, 0, 0, acc);
        n = 0;
        do begin
            drive(o, 1, 0, 0, acc);
            n++;
        end while (!acc && n < 5);
        check("bp_third_accepted", {31'd0, acc}, 32'd1);
        repeat (3) drive(idle, 1, 0, 0, acc);

        // Flush while full, together with a pop and a new valid operation.
        drive(mk(1, OP_RI, 3'd0, 7'd0, 5'd0, 5'd0, 5'd6, 32'd7, 32'd0, 32'd1), 0, 0, 0, acc);
        drive(mk(1, OP_RI, 3'd0, 7'd0, 5'd0, 5'd0, 5'd7, 32'd7, 32'd0, 32'd2), 0, 0, 0, acc);
        drive(mk(1, OP_RI, 3'd0, 7'd0, 5'd0, 5'd0, 5'd3, 32'd7, 32'd0, 32'd3), 1, 1, 0, acc);
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (2) drive(idle, 1, 0, 0, acc);

        // Reset with one entry buffered.
        drive(mk(1, OP_RI, 3'd0, 7'd0, 5'd0, 5'd0, 5'd4, 32'd9, 32'd0, 32'd9), 0, 0, 0, acc);
        drive(idle, 0, 0, 1, acc);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_stall_cnt", stall_cnt, 32'd0);

        // SRAI: immediate operand path and arithmetic shift.
        drive(mk(1, OP_RI, 3'd5, F7_ALT, 5'd0, 5'd0, 5'd5, 32'hFFFF_FFF0, 32'h1234_5678, 32'd2),
              1, 0, 0, acc);
        check("srai_result", out_result, 32'hFFFF_FFFC);
        drive(idle, 1, 0, 0, acc);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            logic [6:0] op;
            n  = int'($urandom_range(0, 2));
            op = (n == 0) ? OP_RR : (n == 1) ? OP_RI : OP_LOAD;
            o = mk(1'($urandom_range(0, 3) != 0), op, 3'($urandom), ($urandom_range(0, 1) != 0) ? F7_ALT : 7'd0,
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   $urandom, $urandom, $urandom);
            drive(o, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 39) == 0),
                  1'($urandom_range(0, 149) == 0), acc);
        end

        n = 0;
        while (sb.size() != 0 && n < 10) begin
            drive(idle, 1, 0, 0, acc);
            n++;
        end
        check("drain_empty", sb.size(), 32'd0);
        drive(idle, 1, 0, 0, acc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exec_issue_ctrl.md
# exec_issue_ctrl

Execute-stage controller that sequences the shared combinational `alu` between decode and memory. It accepts decoded operations through a valid/ready handshake and selects ALU operands and function fields. It captures each result into a 2-entry output skid buffer so that upstream ready is independent of downstream ready. It also supports pipeline flush, optional result forwarding, and a stall-cycle counter.

## Interface
- `N`, 32, data width.
- `RA_W`, 5, register-address width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `flush`  in  1  discards all buffered operations.
- `in_valid`  in  1  a decoded operation is presented.
- `in_ready`  out  1  the controller can accept an operation this cycle.
- `in_opcode`, `in_funct3`, `in_funct7`  in  7/3/7  decoded fields.
- `in_rs1`, `in_rs2`, `in_rd`  in  RA_W  register addresses.
- `in_reg_a`, `in_reg_b`, `in_imm`  in  N  register-file operands and sign-extended immediate.
- `alu_opcode`, `alu_funct3`, `alu_funct7`  out  7/3/7  fields driven to the ALU.
- `alu_a`, `alu_b`  out  N  ALU operands.
- `alu_result`  in  N  combinational ALU result.
- `out_valid`  out  1  the head entry holds a result.
- `out_ready`  in  1  the memory stage accepts the head entry.
- `out_result`  out  N  head result.
- `out_rd`  out  RA_W  head destination register.
- `out_opcode`  out  7  head opcode.
- `stall_cnt`  out  32  count of cycles with `out_valid && !out_ready`.

## Operation
- **Operand and field selection** (combinational, driven from the `in_*` fields every cycle):
  - `alu_a = in_reg_a`, subject to forwarding (see Configuration).
  - `alu_b = in_reg_b` when `in_opcode == OPCODE_REG_REG`; otherwise `alu_b = in_imm`.
  - For shift immediates, the ALU uses `in_imm[4:0]`; the controller passes `in_imm` unmodified.
  - `alu_opcode`, `alu_funct3` and `alu_funct7` mirror the corresponding input fields.
- **Accept:** an operation is accepted when `in_valid && in_ready` at a rising edge. On accept, `{alu_result, in_rd, in_opcode}` is written to the buffer tail.
- **Buffer states:** EMPTY, ONE, TWO.
  - `in_ready = (state != TWO)`.
  - `out_valid = (state != EMPTY)`.
  - The head entry drives `out_result`, `out_rd` and `out_opcode`.
- **Pop:** the head entry leaves when `out_valid && out_ready` at a rising edge.
- **State transitions:**
  - EMPTY: accept → ONE.
  - ONE: accept without pop → TWO; pop without accept → EMPTY; accept and pop together → ONE, with the new entry becoming the head.
  - TWO: pop → ONE, with the skid entry promoted to head. Accept cannot occur because `in_ready = 0`.
- **Ordering:** results leave strictly in acceptance order. No entry is dropped or duplicated.
- **Flush:** `flush` high at an edge forces EMPTY. It overrides any accept or pop in the same cycle; the operation presented that cycle is discarded. `stall_cnt` is unaffected.
- **Stall counter:** `stall_cnt` increments in each cycle with `out_valid && !out_ready`. It saturates at `32'hFFFF_FFFF` and is cleared only by `rst`.
- **Reset** (`rst` high at an edge; overrides `flush`):
  - state → EMPTY, so `in_ready = 1` and `out_valid = 0`.
  - `out_result`, `out_rd`, `out_opcode` → 0.
  - `stall_cnt` → 0.
  - Forwarding tag invalidated.
  - A reset asserted while entries are buffered discards them; no partial result appears afterwards.

## Timing
- **Latency:** an operation accepted at edge k is presented with `out_valid = 1` in the cycle after edge k.
- **Throughput:** one operation per cycle while `out_ready = 1`.
- **Backpressure:** with `out_ready = 0`, two operations are accepted and `in_ready` drops the cycle after the second accept. `in_ready` returns to 1 the cycle after the first pop.
- **Combinational paths:**
  - `in_ready` depends only on registered state.
  - `alu_a` and `alu_b` depend on `in_*` fields and, when forwarding is enabled, on registered state.
  - There is no combinational path from `out_ready` to `in_ready`.

## Configuration
- **`EXEC_FWD_EN` defined:** the controller tracks the most recently accepted operation that writes a register (REG_REG or REG_IMM with rd ≠ 0), recording its rd and result.
  - If `in_rs1` matches that rd, `alu_a` takes the recorded result.
  - If `in_rs2` matches and the opcode is REG_REG, `alu_b` takes the recorded result.
  - The tracking tag survives pops and is invalidated by `flush` and `rst`.
- **`EXEC_FWD_EN` undefined:** operands pass through unchanged and no tracking registers are instantiated.

## Test plan
- **Single ADD:** reset, then REG_REG ADD with a=5, b=3 → `out_valid` high one cycle later, `out_result = 8`.
- **Backpressure:** hold `out_ready = 0` and push ADDI 1, 2, 3 (a=0) → `in_ready = 0` after the second accept. Then raise `out_ready` → results 1, 2, 3 in order, and `stall_cnt` equals the number of held cycles.
- **Forwarding:** ADD x1 = 5 + 3, then ADDI x2 with rs1 = x1, stale `in_reg_a = 0`, imm = 1 → result 9 with `EXEC_FWD_EN` defined, 1 without it.
- **Flush while full:** fill two entries, then assert `flush` together with a pop and a new valid input → next cycle `out_valid = 0`, `in_ready = 1`, and no result is emitted.
- **Reset mid-operation:** fill one entry and assert `rst` → next cycle `out_valid = 0`, `out_result = 0`, `stall_cnt = 0`.
- **Immediate operand:** SRAI with a = FFFF_FFF0, imm = 2, funct7 = SUB_SRA → `alu_b` = imm and `out_result = FFFF_FFFC`.
